// File: rtl/apb_arb_pkg.sv
// Shared types for the APB arbiter: FSM state encoding and the captured request.
package apb_arb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant scanning upward from r_ptr,
// pointer moves to winner+1 (mod NUM_REQ) when i_advance is strobed.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_ptr
);

    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] w_rot;
    logic [PTR_W-1:0]   w_off;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W:0]     w_sum;
    logic               w_found;

    // w_rot[g] is the request sitting g places above the pointer
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rot
        logic [PTR_W:0] w_s;
        assign w_s      = {1'b0, r_ptr} + (PTR_W+1)'(g);
        assign w_rot[g] = i_req[(w_s >= (PTR_W+1)'(NUM_REQ)) ?
                                PTR_W'(w_s - (PTR_W+1)'(NUM_REQ)) : PTR_W'(w_s)];
    end

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off   = PTR_W'(i);
                w_found = 1'b1;
            end
        end
    end

    assign w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win   = (w_sum >= (PTR_W+1)'(NUM_REQ)) ?
                     PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(w_sum);
    assign o_grant = w_found ? (NUM_REQ'(1) << w_win) : '0;
    assign o_ptr   = r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Shares one APB completer among NUM_REQ requesters, one transfer at a time.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                PCLK,
    input  logic                                PRESETn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_slverr,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [ADDR_WIDTH-1:0]               PADDR,
    output logic [DATA_WIDTH-1:0]               PWDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR,
    input  logic [DATA_WIDTH-1:0]               PRDATA
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ADDR_WIDTH > APB_ADDR_W ||
        DATA_WIDTH > APB_DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_arbiter: unsupported parameter set");
    end

    apb_state_e         r_state;
    apb_req_t           r_req;
    apb_req_t           w_sel;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_ptr;
    logic               w_advance;
    logic               w_tmo;
    logic               w_done;

    assign w_advance = (r_state == IDLE) && (|req_valid);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETn),
        .i_req     (req_valid),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_ptr     (w_ptr)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel.write = req_write[i];
                w_sel.addr  = APB_ADDR_W'(req_addr[i]);
                w_sel.wdata = APB_DATA_W'(req_wdata[i]);
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Cleared during SETUP so it starts at zero on the first ACCESS cycle
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ACCESS && !PREADY) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo = (r_state == ACCESS) && !PREADY &&
                   (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_done = (r_state == ACCESS) && (PREADY || w_tmo);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_gnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_advance) begin
                        r_state <= SETUP;
                        r_req   <= w_sel;
                        r_gnt   <= w_grant;
                    end
                end
                SETUP:   r_state <= ACCESS;
                ACCESS:  if (w_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= w_done ? r_gnt : '0;
            if (w_done) begin
                rsp_rdata  <= (r_req.write || w_tmo) ? '0 : PRDATA;
                rsp_slverr <= w_tmo ? 1'b1 : PSLVERR;
            end
        end
    end

    // req_ready depends only on state and req_valid, never on APB inputs
    assign req_ready = (r_state == IDLE) ? w_grant : '0;
    assign PSEL      = (r_state == SETUP) || (r_state == ACCESS);
    assign PENABLE   = (r_state == ACCESS);
    assign PWRITE    = r_req.write;
    assign PADDR     = r_req.addr[ADDR_WIDTH-1:0];
    assign PWDATA    = r_req.wdata[DATA_WIDTH-1:0];

    a_sane: assert property (@(posedge PCLK) disable iff (!PRESETn)
                             (int'(w_ptr) < NUM_REQ) && $onehot0(req_ready));

endmodule

// File: tb/tb_apb_arbiter.sv
// Randomised bench for apb_arbiter against a transaction-level round-robin model.
module tb_apb_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic                 PCLK = 1'b0;
    logic                 PRESETn;
    logic [N-1:0]         req_valid, req_write, req_ready, rsp_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [DW-1:0]        rsp_rdata, PWDATA, PRDATA;
    logic                 rsp_slverr, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]        PADDR;

    int           n_cmp = 0;
    int           n_err = 0;
    int           m_ptr = 0;
    logic [N-1:0] exp_rsp_v = '0;
    logic [DW-1:0] exp_rdata = '0;
    logic         exp_slverr = 1'b0;
    logic         last_wr = 1'b0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_wd = '0;

    apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic apply_reset();
        PRESETn = 1'b0; req_valid = '0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_slverr} !== '0) begin
            n_err++;
            $display("FAIL reset_state: psel=%b pen=%b paddr=%h pwdata=%h rdy=%b rspv=%b rdata=%h err=%b, all must be 0",
                     PSEL, PENABLE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_slverr);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        m_ptr = 0; exp_rsp_v = '0; last_wr = 1'b0; last_a = '0; last_wd = '0;
    endtask

    // Called one step after a rising edge with the arbiter idle; returns one step
    // after the edge that opens the response cycle.
    task automatic run_xfer(input logic [N-1:0] v, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rd,
                            input logic se, output int win);
        int   n_acc;
        logic timed;
        win = rr_pick(v, m_ptr);
        for (int i = 0; i < N; i++) begin
            req_write[i] = 1'($urandom); req_addr[i] = AW'($urandom); req_wdata[i] = DW'($urandom);
        end
        req_write[win] = wr; req_addr[win] = a; req_wdata[win] = wd;
        req_valid = v; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = DW'($urandom);
        @(negedge PCLK);
        n_cmp++;
        if (req_ready !== (N'(1) << win)) begin
            n_err++; $display("FAIL grant: req_ready=%b required %b (valid %b)", req_ready, N'(1) << win, v);
        end
        n_cmp++;
        if (rsp_valid !== exp_rsp_v || (exp_rsp_v != '0 && {rsp_rdata, rsp_slverr} !== {exp_rdata, exp_slverr})) begin
            n_err++; $display("FAIL rsp_at_grant: v=%b d=%h e=%b required v=%b d=%h e=%b",
                              rsp_valid, rsp_rdata, rsp_slverr, exp_rsp_v, exp_rdata, exp_slverr);
        end
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {2'b00, last_wr, last_a, last_wd}) begin
            n_err++; $display("FAIL idle_bus: sel=%b en=%b wr=%b a=%h d=%h required 0 0 %b %h %h",
                              PSEL, PENABLE, PWRITE, PADDR, PWDATA, last_wr, last_a, last_wd);
        end
        m_ptr = (win + 1) % N;
        exp_rsp_v = '0;
        @(posedge PCLK); #1;
        req_valid = v & ~(N'(1) << win);
        @(negedge PCLK);
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid} !== {2'b10, wr, a, wd, N'(0), N'(0)}) begin
            n_err++; $display("FAIL setup: sel=%b en=%b wr=%b a=%h d=%h rdy=%b rspv=%b required 1 0 %b %h %h 0 0",
                              PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, wr, a, wd);
        end
        last_wr = wr; last_a = a; last_wd = wd;
        n_acc = waits + 1; timed = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        if (n_acc > TMO) begin n_acc = TMO; timed = 1'b1; end
`endif
        for (int k = 0; k < n_acc; k++) begin
            @(posedge PCLK); #1;
            PREADY  = !timed && (k == n_acc - 1);
            PRDATA  = PREADY ? rd : DW'($urandom);
            PSLVERR = PREADY ? se : 1'($urandom);
            @(negedge PCLK);
            n_cmp++;
            if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid} !== {2'b11, wr, a, wd, N'(0), N'(0)}) begin
                n_err++; $display("FAIL access%0d: sel=%b en=%b wr=%b a=%h d=%h rdy=%b rspv=%b required 1 1 %b %h %h 0 0",
                                  k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, wr, a, wd);
            end
        end
        @(posedge PCLK); #1;
        PREADY = 1'b0; PSLVERR = 1'b0; req_valid = '0;
        exp_rsp_v  = N'(1) << win;
        exp_rdata  = (wr || timed) ? '0 : rd;
        exp_slverr = timed ? 1'b1 : se;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge PCLK);
            n_cmp++;
            if (rsp_valid !== exp_rsp_v || (exp_rsp_v != '0 && {rsp_rdata, rsp_slverr} !== {exp_rdata, exp_slverr})) begin
                n_err++; $display("FAIL rsp_idle: v=%b d=%h e=%b required v=%b d=%h e=%b",
                                  rsp_valid, rsp_rdata, rsp_slverr, exp_rsp_v, exp_rdata, exp_slverr);
            end
            n_cmp++;
            if ({PSEL, PENABLE, req_ready, PWRITE, PADDR, PWDATA} !== {2'b00, N'(0), last_wr, last_a, last_wd}) begin
                n_err++; $display("FAIL idle_hold: sel=%b en=%b rdy=%b wr=%b a=%h d=%h required 0 0 0 %b %h %h",
                                  PSEL, PENABLE, req_ready, PWRITE, PADDR, PWDATA, last_wr, last_a, last_wd);
            end
            exp_rsp_v = '0;
            @(posedge PCLK); #1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        idle_cycles(2);
    endtask

    task automatic test_single_read();
        int w;
        run_xfer(N'(1), 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0, w);
        idle_cycles(2);
    endtask

    task automatic test_write_wait();
        int w;
        run_xfer(N'(2), 1'b1, 32'h20, 32'hA5A5A5A5, 3, DW'($urandom), 1'b0, w);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int w;
        apply_reset();
        for (int i = 0; i < 4; i++)
            run_xfer(N'(3), 1'b0, AW'($urandom), DW'($urandom), 0, DW'($urandom), 1'b0, w);
        idle_cycles(2);
    endtask

    task automatic test_slverr();
        int w;
        run_xfer(N'($urandom_range(1, (1 << N) - 1)), 1'b0, AW'($urandom), DW'($urandom), 1, DW'($urandom), 1'b1, w);
        run_xfer(N'($urandom_range(1, (1 << N) - 1)), 1'b1, AW'($urandom), DW'($urandom), 0, DW'($urandom), 1'b0, w);
        idle_cycles(2);
    endtask

    task automatic test_reset_in_flight();
        req_valid = N'(1); req_write = '0; req_addr[0] = 32'h44; req_wdata[0] = 32'h55;
        @(posedge PCLK); #1; req_valid = '0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0; PREADY = 1'b1; PSLVERR = 1'b1;
        #1;
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_slverr} !== '0) begin
            n_err++; $display("FAIL reset_in_access: sel=%b en=%b a=%h d=%h rspv=%b, all must be 0",
                              PSEL, PENABLE, PADDR, PWDATA, rsp_valid);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
        m_ptr = 0; exp_rsp_v = '0; last_wr = 1'b0; last_a = '0; last_wd = '0;
        idle_cycles(3);
        begin
            int w;
            run_xfer(N'(7), 1'b0, AW'($urandom), DW'($urandom), 0, DW'($urandom), 1'b0, w);
        end
        idle_cycles(1);
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 40; i++)
            run_xfer(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom), AW'($urandom), DW'($urandom),
                     $urandom_range(0, 4), DW'($urandom), 1'($urandom), w);
        idle_cycles(2);
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        run_xfer(N'(1), 1'b0, 32'h80, 32'h0, 100, DW'($urandom), 1'b0, w);
        run_xfer(N'(2), 1'b0, 32'h84, 32'h0, TMO - 1, 32'h1234, 1'b0, w);
        idle_cycles(2);
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_back_to_back();
        test_slverr();
        test_reset_in_flight();
        test_random();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
